// File: rtl/pkt_pkg.sv
// Shared packet definitions for the vehicle radio link.
// Used by the transmit scheduler and the receive handler.
package pkt_pkg;

  localparam int FRAME_BYTES = 4;
  localparam logic [7:0] KILL_ID = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  typedef struct packed {
    logic [7:0]  dest;
    logic [7:0]  src;
    logic [15:0] data;
  } frame_t;

  function automatic logic [7:0] frame_byte(
    input frame_t     f,
    input logic [1:0] idx
  );
    logic [7:0] b;
    unique case (idx)
      2'd0: b = f.dest;
      2'd1: b = f.src;
      2'd2: b = f.data[15:8];
      2'd3: b = f.data[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin requester select.
// Picks the first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic          any
);

  logic found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    any   = |req;
    for (int i = 0; i < N; i++) begin
      logic [PW-1:0] k;
      k = PW'((int'(ptr) + i) % N);
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pkt_tx_sched.sv
// Transmit scheduler: arbitrates requesters and kill frames,
// serialises 4-byte frames to the radio, then holds off a gap.
module pkt_tx_sched
  import pkt_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            veh_id,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [8*NUM_REQ-1:0]  req_dest,
  input  logic [16*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  kill_req,
  output logic                  kill_ack,
  output logic [7:0]            tx_byte,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  err_drop
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [1:0] LAST = 2'(FRAME_BYTES - 1);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    gap_q, gap_d;
  frame_t        frame_q, frame_d;

  logic [NUM_REQ-1:0] grant;
  logic               any;
  logic [PW-1:0]      gidx;
  logic [7:0]         gdest;
  logic [15:0]        gdata;

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (grant),
    .any   (any)
  );

  always_comb begin
    gidx  = '0;
    gdest = '0;
    gdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        gidx  = PW'(i);
        gdest = req_dest[8*i +: 8];
        gdata = req_data[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      ptr_q   <= '0;
      gap_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      gap_q   <= gap_d;
      frame_q <= frame_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ptr_d     = ptr_q;
    gap_d     = gap_q;
    frame_d   = frame_q;
    req_ready = '0;
    kill_ack  = 1'b0;
    err_drop  = 1'b0;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (kill_req) begin
          frame_d  = '{dest: KILL_ID, src: veh_id, data: 16'h0000};
          kill_ack = 1'b1;
          idx_d    = '0;
          state_d  = SEND;
        end else if (any) begin
          req_ready = grant;
          ptr_d = (gidx == PW'(NUM_REQ - 1)) ? '0 : gidx + PW'(1);
          // Broadcast ID is reserved for kill; requesters may not use it.
          if (gdest == KILL_ID) begin
            err_drop = 1'b1;
          end else begin
            frame_d = '{dest: gdest, src: veh_id, data: gdata};
            idx_d   = '0;
            state_d = SEND;
          end
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        tx_byte  = frame_byte(frame_q, idx_q);
        if (tx_ready) begin
          if (idx_q == LAST) begin
            idx_d = '0;
            if (GAP_CYCLES > 0) begin
              state_d = GAP;
              gap_d   = 8'(GAP_CYCLES - 1);
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      GAP: begin
        if (gap_q == 8'd0) state_d = IDLE;
        else gap_d = gap_q - 8'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_pkt_tx_sched.sv
// Directed self-checking bench for pkt_tx_sched.
// Each task drives one scenario and checks its own results.
module tb_pkt_tx_sched;

  localparam int N = 3;
  localparam int G = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [7:0]     veh_id = 8'h12;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_dest = '0;
  logic [16*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic           kill_req = 1'b0;
  logic           kill_ack;
  logic [7:0]     tx_byte;
  logic           tx_valid;
  logic           tx_ready = 1'b1;
  logic           busy;
  logic           err_drop;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  pkt_tx_sched #(
    .NUM_REQ    (N),
    .GAP_CYCLES (G)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .veh_id    (veh_id),
    .req_valid (req_valid),
    .req_dest  (req_dest),
    .req_data  (req_data),
    .req_ready (req_ready),
    .kill_req  (kill_req),
    .kill_ack  (kill_ack),
    .tx_byte   (tx_byte),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .err_drop  (err_drop)
  );

  task automatic set_req(input int i, input logic [7:0] d,
                         input logic [15:0] p);
    req_dest[8*i +: 8]   = d;
    req_data[16*i +: 16] = p;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    kill_req = 1'b0;
    req_valid = '0;
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic collect(output logic [31:0] got, output int n);
    got = '0;
    n = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      #1;
      if (tx_valid && tx_ready) begin
        got = {got[23:0], tx_byte};
        n++;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    vecs++; if (tx_valid !== 1'b0) begin errs++;
      $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
    vecs++; if (tx_byte !== 8'h00) begin errs++;
      $display("FAIL rst_tx_byte: got %h want 00", tx_byte); end
    vecs++; if (req_ready !== 3'b000) begin errs++;
      $display("FAIL rst_req_ready: got %b want 000", req_ready); end
    vecs++; if ({kill_ack, err_drop, busy} !== 3'b000) begin errs++;
      $display("FAIL rst_flags: got %b want 000",
               {kill_ack, err_drop, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    logic [31:0] got;
    int n;
    bit ok;
    @(negedge clk);
    set_req(0, 8'h05, 16'hABCD);
    req_valid = 3'b001;
    #1;
    vecs++; if (req_ready !== 3'b001) begin errs++;
      $display("FAIL single_grant: got %b want 001", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    collect(got, n);
    vecs++; if (n != 4) begin errs++;
      $display("FAIL single_count: got %0d want 4", n); end
    vecs++; if (got !== 32'h0512ABCD) begin errs++;
      $display("FAIL single_bytes: got %h want 0512abcd", got); end
    for (int i = 0; i < G; i++) begin
      @(negedge clk);
      #1;
      vecs++; if ({tx_valid, busy} !== 2'b01) begin errs++;
        $display("FAIL single_gap%0d: got valid,busy=%b want 01",
                 i, {tx_valid, busy}); end
    end
    @(negedge clk);
    #1;
    vecs++; if (busy !== 1'b0) begin errs++;
      $display("FAIL single_idle: got busy=%b want 0", busy); end
    ok = 1'b1;
  endtask

  task automatic test_kill();
    logic [31:0] got;
    int n;
    bit ok;
    @(negedge clk);
    set_req(1, 8'h21, 16'h3344);
    req_valid = 3'b011;
    kill_req = 1'b1;
    #1;
    vecs++; if (kill_ack !== 1'b1) begin errs++;
      $display("FAIL kill_ack: got %b want 1", kill_ack); end
    vecs++; if ({req_ready, err_drop} !== 4'b0000) begin errs++;
      $display("FAIL kill_excl: got %b want 0000",
               {req_ready, err_drop}); end
    @(posedge clk);
    #1;
    kill_req = 1'b0;
    collect(got, n);
    vecs++; if (n != 4 || got !== 32'hFF120000) begin errs++;
      $display("FAIL kill_bytes: got %h (%0d) want ff120000", got, n); end
    wait_idle(ok);
    vecs++; if (!ok) begin errs++;
      $display("FAIL kill_idle: got timeout want idle"); end
    vecs++; if (req_ready !== 3'b010) begin errs++;
      $display("FAIL kill_ptr: got %b want 010", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    collect(got, n);
    vecs++; if (n != 4 || got !== 32'h21123344) begin errs++;
      $display("FAIL kill_req1: got %h (%0d) want 21123344", got, n); end
    wait_idle(ok);
  endtask

  task automatic test_round_robin();
    logic [N-1:0] order [4];
    logic [N-1:0] prev;
    logic [N-1:0] want;
    int g;
    bit ok;
    do_reset();
    g = 0;
    prev = '0;
    @(negedge clk);
    set_req(0, 8'h10, 16'h0000);
    set_req(1, 8'h11, 16'h1111);
    set_req(2, 8'h12, 16'h2222);
    req_valid = 3'b111;
    for (int c = 0; c < 200 && g < 4; c++) begin
      #1;
      if (req_ready != '0) begin
        vecs++; if (!$onehot(req_ready) || prev != '0) begin errs++;
          $display("FAIL rr_pulse: got %b prev %b want one-hot single",
                   req_ready, prev); end
        order[g] = req_ready;
        g++;
      end
      prev = req_ready;
      if (g < 4) @(negedge clk);
    end
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_idle(ok);
    vecs++; if (g != 4) begin errs++;
      $display("FAIL rr_count: got %0d want 4", g); end
    for (int i = 0; i < g; i++) begin
      want = 3'b001 << (i % 3);
      vecs++; if (order[i] !== want) begin errs++;
        $display("FAIL rr_order%0d: got %b want %b", i, order[i], want); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] got;
    logic [7:0] held;
    bit stalled;
    int n;
    bit ok;
    got = '0;
    n = 0;
    stalled = 1'b0;
    held = '0;
    @(negedge clk);
    set_req(1, 8'h5A, 16'h1234);
    req_valid = 3'b010;
    #1;
    vecs++; if (req_ready !== 3'b010) begin errs++;
      $display("FAIL stall_grant: got %b want 010", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      @(negedge clk);
      tx_ready = (c % 3 == 0);
      #1;
      vecs++; if (tx_valid !== 1'b1) begin errs++;
        $display("FAIL stall_valid: got %b want 1", tx_valid); end
      if (stalled) begin
        vecs++; if (tx_byte !== held) begin errs++;
          $display("FAIL stall_hold: got %h want %h", tx_byte, held); end
      end
      if (tx_valid && tx_ready) begin
        got = {got[23:0], tx_byte};
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = tx_byte;
      end
    end
    tx_ready = 1'b1;
    vecs++; if (n != 4 || got !== 32'h5A121234) begin errs++;
      $display("FAIL stall_bytes: got %h (%0d) want 5a121234", got, n); end
    @(negedge clk);
    #1;
    vecs++; if (tx_valid !== 1'b0) begin errs++;
      $display("FAIL stall_extra: got %b want 0", tx_valid); end
    wait_idle(ok);
  endtask

  task automatic test_drop();
    logic [31:0] got;
    int n;
    bit ok;
    do_reset();
    @(negedge clk);
    set_req(0, 8'h31, 16'h0102);
    set_req(1, 8'hFF, 16'hDEAD);
    set_req(2, 8'hFF, 16'hBEEF);
    req_valid = 3'b010;
    #1;
    vecs++; if ({req_ready, err_drop, busy} !== 5'b01010) begin errs++;
      $display("FAIL drop1: got rdy,drop,busy=%b want 01010",
               {req_ready, err_drop, busy}); end
    @(negedge clk);
    req_valid = 3'b101;
    #1;
    vecs++; if ({req_ready, err_drop, tx_valid} !== 5'b10010) begin errs++;
      $display("FAIL drop2: got rdy,drop,valid=%b want 10010",
               {req_ready, err_drop, tx_valid}); end
    @(negedge clk);
    #1;
    vecs++; if ({req_ready, err_drop, tx_valid} !== 5'b00100) begin errs++;
      $display("FAIL drop_next: got rdy,drop,valid=%b want 00100",
               {req_ready, err_drop, tx_valid}); end
    @(posedge clk);
    #1;
    req_valid = '0;
    collect(got, n);
    vecs++; if (n != 4 || got !== 32'h31120102) begin errs++;
      $display("FAIL drop_frame: got %h (%0d) want 31120102", got, n); end
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    logic [31:0] got;
    int n;
    bit ok;
    @(negedge clk);
    set_req(0, 8'h77, 16'h8899);
    req_valid = 3'b001;
    #1;
    vecs++; if (req_ready !== 3'b001) begin errs++;
      $display("FAIL mid_grant: got %b want 001", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    #1;
    vecs++; if ({tx_valid, tx_byte} !== 9'h177) begin errs++;
      $display("FAIL mid_b0: got %h want 177", {tx_valid, tx_byte}); end
    @(negedge clk);
    #1;
    vecs++; if ({tx_valid, tx_byte} !== 9'h112) begin errs++;
      $display("FAIL mid_b1: got %h want 112", {tx_valid, tx_byte}); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++; if ({tx_valid, tx_byte, busy} !== 10'h000) begin errs++;
      $display("FAIL mid_rst: got valid,byte,busy=%h want 000",
               {tx_valid, tx_byte, busy}); end
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 8'h66, 16'h5544);
    req_valid = 3'b010;
    #1;
    vecs++; if (req_ready !== 3'b010) begin errs++;
      $display("FAIL mid_regrant: got %b want 010", req_ready); end
    @(posedge clk);
    #1;
    req_valid = '0;
    collect(got, n);
    vecs++; if (n != 4 || got !== 32'h66125544) begin errs++;
      $display("FAIL mid_frame: got %h (%0d) want 66125544", got, n); end
    wait_idle(ok);
  endtask

  initial begin
    test_reset();
    test_single();
    test_kill();
    test_round_robin();
    test_stall();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pkt_tx_sched.md
PKT_TX_SCHED -- requirements
Module: pkt_tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 3, SHALL set the number of frame requesters (2..8).
REQ-002 Parameter GAP_CYCLES, default 4, SHALL set the idle cycles inserted after each frame (0..255).
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 veh_id  input  8  own vehicle ID, placed in byte 1 of every frame.
REQ-006 req_valid  input  NUM_REQ  per-requester frame pending.
REQ-007 req_dest  input  8*NUM_REQ  per-requester destination vehicle ID.
REQ-008 req_data  input  16*NUM_REQ  per-requester payload.
REQ-009 req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse.
REQ-010 kill_req  input  1  level request to broadcast a kill frame.
REQ-011 kill_ack  output  1  one-cycle pulse when a kill frame is latched.
REQ-012 tx_byte  output  8  serial byte to radio.
REQ-013 tx_valid  output  1  tx_byte valid.
REQ-014 tx_ready  input  1  radio accepts byte when tx_valid && tx_ready.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 err_drop  output  1  one-cycle pulse when a requester frame is discarded.

Function
REQ-017 Frame SHALL be 4 bytes, in order: dest, veh_id, data[15:8], data[7:0].
REQ-018 Kill frame SHALL be FF, veh_id, 00, 00.
REQ-019 FSM states SHALL be IDLE, SEND, GAP; state is held in a register.
REQ-020 In IDLE with kill_req high, the block SHALL latch the kill frame, pulse kill_ack, and enter SEND next cycle; kill takes priority over all requesters.
REQ-021 In IDLE with kill_req low and any req_valid high, the block SHALL grant the first valid requester found searching upward from rr_ptr (wrapping), pulse req_ready for that requester in the same cycle, latch its dest/data plus the current veh_id, and enter SEND.
REQ-022 After a requester grant, rr_ptr SHALL become (grant+1) mod NUM_REQ; kill grants SHALL NOT change rr_ptr.
REQ-023 A granted requester frame with dest == 8'hFF SHALL be consumed (req_ready pulses), pulse err_drop, not be transmitted, and leave FSM in IDLE; rr_ptr still advances.
REQ-024 In SEND, tx_valid SHALL be 1 and tx_byte SHALL equal the byte at byte_idx (0..3); byte_idx advances only on tx_valid && tx_ready.
REQ-025 tx_byte SHALL remain stable while tx_valid && !tx_ready.
REQ-026 Acceptance of byte 3 SHALL move to GAP when GAP_CYCLES > 0, else to IDLE; tx_valid is 0 in the following cycle.
REQ-027 GAP SHALL last exactly GAP_CYCLES cycles, then IDLE; no grants occur in SEND or GAP.
REQ-028 First byte latency: tx_valid rises the cycle after the grant.
REQ-029 Changes on req_* or kill_req while in SEND or GAP SHALL NOT affect the frame in flight; kill_req still high on return to IDLE is served first.
REQ-030 req_ready, kill_ack, err_drop SHALL never be high simultaneously; each is 0 outside IDLE.

Reset
REQ-031 On rst_n low: state IDLE, byte_idx 0, rr_ptr 0, gap counter 0, frame register 0.
REQ-032 Reset outputs: tx_valid 0, tx_byte 8'h00, req_ready 0, kill_ack 0, err_drop 0, busy 0.
REQ-033 Reset mid-frame SHALL abort the frame immediately; no partial bytes resume after release.

Structure
REQ-034 Package pkt_pkg SHALL hold FRAME_BYTES=4, KILL_ID=8'hFF, and the FSM state enum, shared with the receive handler.
REQ-035 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req vector, ptr; outputs one-hot grant, any).

Verification
REQ-036 veh_id=0x12, req0 dest=0x05 data=0xABCD, tx_ready=1 -> bytes 05,12,AB,CD on 4 consecutive cycles, then 4 idle cycles, busy low.
REQ-037 req0,req1,req2 held valid continuously -> grant order 0,1,2,0; each req_ready single-cycle.
REQ-038 kill_req and req1 asserted together in IDLE -> kill_ack, frame FF,12,00,00, then req1 frame; rr_ptr unchanged by kill.
REQ-039 tx_ready toggled 1,0,0,1,... during frame -> tx_byte held while stalled; exactly 4 bytes delivered in order.
REQ-040 req2 dest=0xFF -> req_ready[2] and err_drop pulse, no tx_valid, next grant starts from req0.
REQ-041 rst_n pulsed low after byte 1 accepted -> tx_valid 0 during reset; next frame starts at byte 0.
